// File: rtl/m10k_stream_reader.sv
// Burst reader for the M10K wrapper: issues credit-limited word reads and returns them as a valid/ready stream.
// Optional `M10K_STREAM_LAST_EN adds out_last_o, a per-entry tag marking the final word of a burst.
module m10k_stream_reader #(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  base_addr_i,
  input  logic [8:0]  length_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_read_o,
  output logic [7:0]  mem_address_o,
  input  logic [31:0] mem_readdata_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
`ifdef M10K_STREAM_LAST_EN
  output logic        out_last_o,
`endif
  input  logic        out_ready_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // IDLE: waiting for start | ISSUE: reads issued as credit allows | DRAIN: all reads issued, emptying
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q;
  logic [7:0]              addr_q;
  logic [8:0]              remaining_q;
  logic                    busy_q, done_q, mem_read_q;
  logic [7:0]              mem_address_q;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [31:0]             fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    push, pop, credit;
  int                      used;
`ifdef M10K_STREAM_LAST_EN
  logic                    mem_last_q;
  logic [READ_LATENCY-1:0] last_pipe_q;
  logic                    fifo_last_q [FIFO_DEPTH];
`endif

  assign push          = pipe_q[READ_LATENCY-1];
  assign out_valid_o   = (count_q != '0);
  assign pop           = out_valid_o && out_ready_i;
  assign out_data_o    = fifo_data_q[rd_ptr_q];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_read_o    = mem_read_q;
  assign mem_address_o = mem_address_q;
`ifdef M10K_STREAM_LAST_EN
  assign out_last_o    = out_valid_o && fifo_last_q[rd_ptr_q];
`endif

  // Reads are registered, so the decision counts the read on the bus this cycle as already in flight.
  always_comb begin
    used = int'(count_q) - (pop ? 1 : 0) + (mem_read_q ? 1 : 0);
    for (int i = 0; i < READ_LATENCY; i++) begin
      used = used + (pipe_q[i] ? 1 : 0);
    end
    credit = (used < FIFO_DEPTH);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      pipe_q        <= '0;
`ifdef M10K_STREAM_LAST_EN
      mem_last_q    <= 1'b0;
      last_pipe_q   <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      mem_read_q <= 1'b0;
      pipe_q[0]  <= mem_read_q;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
`ifdef M10K_STREAM_LAST_EN
      mem_last_q     <= 1'b0;
      last_pipe_q[0] <= mem_read_q && mem_last_q;
      for (int i = 1; i < READ_LATENCY; i++) last_pipe_q[i] <= last_pipe_q[i-1];
`endif
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (length_i == 9'd0) begin
              done_q <= 1'b1;
            end else begin
              mem_read_q    <= 1'b1;
              mem_address_q <= base_addr_i;
              addr_q        <= base_addr_i + 8'd1;
              remaining_q   <= length_i - 9'd1;
              busy_q        <= 1'b1;
              state_q       <= (length_i == 9'd1) ? DRAIN : ISSUE;
`ifdef M10K_STREAM_LAST_EN
              mem_last_q    <= (length_i == 9'd1);
`endif
            end
          end
        end
        ISSUE: begin
          if (credit) begin
            mem_read_q    <= 1'b1;
            mem_address_q <= addr_q;
            addr_q        <= addr_q + 8'd1;
            remaining_q   <= remaining_q - 9'd1;
            if (remaining_q == 9'd1) state_q <= DRAIN;
`ifdef M10K_STREAM_LAST_EN
            mem_last_q    <= (remaining_q == 9'd1);
`endif
          end
        end
        DRAIN: begin
          if (!mem_read_q && (pipe_q == '0) && (count_q == CW'(1)) && pop) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
`ifdef M10K_STREAM_LAST_EN
        fifo_last_q[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata_i;
`ifdef M10K_STREAM_LAST_EN
        fifo_last_q[wr_ptr_q] <= last_pipe_q[READ_LATENCY-1];
`endif
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule
